// File: rtl/rcu_pkg.sv
// rcu_pkg: shared PLL-controller types, default parameters and the clock-config width define
`ifndef RCU_CLK_CFG_WIDTH
`define RCU_CLK_CFG_WIDTH 8
`endif
package rcu_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PWRUP     = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } pll_state_e;
  localparam int PWRUP_CYC_DEF   = 16;
  localparam int LOCK_CNT_DEF    = 32;
  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int CNT_WIDTH_DEF   = 16;
endpackage

// File: rtl/rcu_sync2.sv
// rcu_sync2: two-flop synchronizer with synchronous active-high reset
// Ports: clk_i destination clock, rst_i sync reset, d_i async input, q_o synchronized output
module rcu_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk_i) ff_q <= rst_i ? 2'b00 : {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/rcu_pll_ctrl.sv
// rcu_pll_ctrl: PLL power-up, lock qualification and glitch-free clock switch sequencer
// Ports: ref_clk_i clock, rst_i sync reset, pll_en_i software request, clr_i sticky clear,
//        pll_lock_i raw async lock; pll_en_o PLL enable, clk_sel_o 1=PLL clock, pll_ready_o in RUN,
//        timeout_o sticky lock timeout, lol_o sticky loss of lock, state_o FSM state.
// Build option: RCU_PLL_TIMEOUT_EN enables the WAIT_LOCK timeout and the FAIL state.
module rcu_pll_ctrl
  import rcu_pkg::*;
#(
  parameter int PWRUP_CYC   = PWRUP_CYC_DEF,
  parameter int LOCK_CNT    = LOCK_CNT_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic       ref_clk_i,
  input  logic       rst_i,
  input  logic       pll_en_i,
  input  logic       clr_i,
  input  logic       pll_lock_i,
  output logic       pll_en_o,
  output logic       clk_sel_o,
  output logic       pll_ready_o,
  output logic       timeout_o,
  output logic       lol_o,
  output logic [2:0] state_o
);
`ifdef RCU_PLL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  pll_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic lock_s, pll_en_q, pll_en_d, clk_sel_q, clk_sel_d, ready_q, ready_d;
  logic lol_q, timeout_q, lol_set, to_set;
  rcu_sync2 u_sync (
    .clk_i (ref_clk_i),
    .rst_i (rst_i),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    pll_en_d  = pll_en_q;
    clk_sel_d = clk_sel_q;
    ready_d   = ready_q;
    lol_set   = 1'b0;
    to_set    = 1'b0;
    if (!pll_en_i && state_q != IDLE) begin
      // deselect the PLL clock now; pll_en_o drops from IDLE one edge later
      state_d   = IDLE;
      cnt_d     = '0;
      clk_sel_d = 1'b0;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = pll_en_i ? PWRUP : IDLE;
          cnt_d    = '0;
          pll_en_d = pll_en_i;
        end
        PWRUP: if (cnt_q == CNT_WIDTH'(PWRUP_CYC - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
        WAIT_LOCK: if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (TO_EN && cnt_q == CNT_WIDTH'(TIMEOUT_CYC - 1)) begin
          state_d  = FAIL;
          cnt_d    = '0;
          pll_en_d = 1'b0;
          to_set   = 1'b1;
        end
        STABLE: if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_WIDTH'(LOCK_CNT - 1)) begin
          state_d   = RUN;
          cnt_d     = '0;
          clk_sel_d = 1'b1;
          ready_d   = 1'b1;
        end
        RUN: begin
          cnt_d = '0;
          if (!lock_s) begin
            state_d   = WAIT_LOCK;
            clk_sel_d = 1'b0;
            ready_d   = 1'b0;
            lol_set   = 1'b1;
          end
        end
        FAIL: cnt_d = '0;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end
  always_ff @(posedge ref_clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pll_en_q  <= 1'b0;
      clk_sel_q <= 1'b0;
      ready_q   <= 1'b0;
      lol_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_en_q  <= pll_en_d;
      clk_sel_q <= clk_sel_d;
      ready_q   <= ready_d;
      lol_q     <= lol_set | (lol_q & ~clr_i);
      timeout_q <= to_set | (timeout_q & ~clr_i);
    end
  end
  assign pll_en_o    = pll_en_q;
  assign clk_sel_o   = clk_sel_q;
  assign pll_ready_o = ready_q;
  assign lol_o       = lol_q;
  assign timeout_o   = TO_EN & timeout_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_rcu_pll_ctrl.sv
// tb_rcu_pll_ctrl: randomized scenario bench with an arithmetic timeline model of the PLL sequencer
module tb_rcu_pll_ctrl;
  localparam int PW = 4, LC = 8, TO = 64;
  localparam int S = 2 + PW, R = 2 + PW + LC;
  logic ref_clk_i = 1'b0;
  logic rst_i = 1'b1, pll_en_i = 1'b0, clr_i = 1'b0, pll_lock_i = 1'b0;
  logic pll_en_o, clk_sel_o, pll_ready_o, timeout_o, lol_o;
  logic [2:0] state_o;
  int n_chk = 0, n_fail = 0;
  rcu_pll_ctrl #(.PWRUP_CYC(PW), .LOCK_CNT(LC), .TIMEOUT_CYC(TO), .CNT_WIDTH(16)) dut (
    .ref_clk_i   (ref_clk_i),
    .rst_i       (rst_i),
    .pll_en_i    (pll_en_i),
    .clr_i       (clr_i),
    .pll_lock_i  (pll_lock_i),
    .pll_en_o    (pll_en_o),
    .clk_sel_o   (clk_sel_o),
    .pll_ready_o (pll_ready_o),
    .timeout_o   (timeout_o),
    .lol_o       (lol_o),
    .state_o     (state_o)
  );
  always #5 ref_clk_i = ~ref_clk_i;
  task automatic tick;
    @(posedge ref_clk_i);
    #1;
  endtask
  // expected state n edges after pll_en_i rises with lock held high
  function automatic logic [2:0] nom_state(int n);
    return n < 1 + PW ? 3'd1 : n < S ? 3'd2 : n < R ? 3'd3 : 3'd4;
  endfunction
  function automatic logic [7:0] got_vec();
    return {state_o, pll_en_o, clk_sel_o, pll_ready_o, lol_o, timeout_o};
  endfunction
  task automatic go_idle;
    rst_i = 1'b0;
    pll_en_i = 1'b0;
    pll_lock_i = 1'b1;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    repeat (3) tick();
  endtask
  task automatic test_reset;
    logic [7:0] g;
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pll_en_i = 1'($urandom);
      pll_lock_i = 1'($urandom);
      clr_i = 1'($urandom);
      tick();
      g = got_vec();
      n_chk++;
      if (g !== 8'h00) begin
        n_fail++;
        $display("FAIL reset edge %0d: got %b want %b", i, g, 8'h00);
      end
    end
  endtask
  task automatic test_nominal;
    logic [7:0] g, e;
    logic [2:0] st;
    go_idle();
    pll_en_i = 1'b1;
    for (int n = 1; n <= R + 3; n++) begin
      tick();
      st = nom_state(n);
      e = {st, 1'b1, st == 3'd4, st == 3'd4, 2'b00};
      g = got_vec();
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL nominal edge %0d: got %b want %b", n, g, e);
      end
    end
  endtask
  task automatic test_lock_glitch;
    logic [7:0] g, e;
    logic [2:0] st;
    int p, l, gl;
    p = $urandom_range(0, LC - 3);
    l = $urandom_range(1, 3);
    gl = S + p + 3;
    go_idle();
    pll_en_i = 1'b1;
    for (int n = 1; n <= gl + l + LC + 2; n++) begin
      tick();
      st = n < gl ? nom_state(n) : n < gl + l ? 3'd2 : n < gl + l + LC ? 3'd3 : 3'd4;
      e = {st, 1'b1, st == 3'd4, st == 3'd4, 2'b00};
      g = got_vec();
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL glitch p=%0d l=%0d edge %0d: got %b want %b", p, l, n, g, e);
      end
      pll_lock_i = !(n >= S + p && n < S + p + l);
    end
    pll_lock_i = 1'b1;
  endtask
  task automatic test_loss_of_lock;
    logic [7:0] g, e;
    logic [2:0] st;
    logic lol;
    int d, l, c;
    d = R + $urandom_range(0, 5);
    l = $urandom_range(1, 4);
    c = d + 3 + l + LC + 2;
    go_idle();
    pll_en_i = 1'b1;
    for (int n = 1; n <= c + 3; n++) begin
      tick();
      st = n < d + 3 ? nom_state(n) : n < d + 3 + l ? 3'd2 : n < d + 3 + l + LC ? 3'd3 : 3'd4;
      lol = n >= d + 3 && n <= c;
      e = {st, 1'b1, st == 3'd4, st == 3'd4, lol, 1'b0};
      g = got_vec();
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL lol d=%0d l=%0d edge %0d: got %b want %b", d, l, n, g, e);
      end
      pll_lock_i = !(n >= d && n < d + l);
      // first clr coincides with the loss-of-lock set and must lose to it
      clr_i = n == d + 2 || n == c;
    end
    clr_i = 1'b0;
    pll_lock_i = 1'b1;
  endtask
  task automatic test_shutdown;
    logic [7:0] g, e;
    logic [2:0] st;
    int x;
    x = R - 1 + $urandom_range(0, 3);
    go_idle();
    pll_en_i = 1'b1;
    for (int n = 1; n <= x + 3; n++) begin
      tick();
      st = n <= x ? nom_state(n) : 3'd0;
      e = {st, n <= x + 1, st == 3'd4, st == 3'd4, 2'b00};
      g = got_vec();
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL shutdown x=%0d edge %0d: got %b want %b", x, n, g, e);
      end
      pll_en_i = n < x;
    end
  endtask
  task automatic test_reset_in_run;
    logic [7:0] g;
    go_idle();
    pll_en_i = 1'b1;
    repeat (R + 2) tick();
    g = got_vec();
    n_chk++;
    if (g !== {3'd4, 3'b111, 2'b00}) begin
      n_fail++;
      $display("FAIL run_before_reset: got %b want %b", g, {3'd4, 3'b111, 2'b00});
    end
    rst_i = 1'b1;
    tick();
    g = got_vec();
    n_chk++;
    if (g !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_in_run: got %b want %b", g, 8'h00);
    end
    rst_i = 1'b0;
  endtask
`ifdef RCU_PLL_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] g, e;
    logic [2:0] st;
    logic en;
    int f;
    f = 1 + PW + TO;
    go_idle();
    pll_lock_i = 1'b0;
    repeat (3) tick();
    pll_en_i = 1'b1;
    for (int n = 1; n <= f + 5; n++) begin
      tick();
      st = n < 1 + PW ? 3'd1 : n < f ? 3'd2 : n <= f + 2 ? 3'd5 : n == f + 3 ? 3'd0 : 3'd1;
      en = n < f || n >= f + 4;
      e = {st, en, 3'b000, n >= f};
      g = got_vec();
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL timeout edge %0d: got %b want %b", n, g, e);
      end
      pll_en_i = n != f + 2;
    end
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    n_chk++;
    if (timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clr: got %b want 0", timeout_o);
    end
  endtask
`else
  task automatic test_no_timeout;
    logic [7:0] g, e;
    go_idle();
    pll_lock_i = 1'b0;
    repeat (3) tick();
    pll_en_i = 1'b1;
    for (int n = 1; n <= 10000; n++) begin
      tick();
      e = {n < 1 + PW ? 3'd1 : 3'd2, 1'b1, 4'b0000};
      g = got_vec();
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL no_timeout edge %0d: got %b want %b", n, g, e);
      end
    end
  endtask
`endif
  initial begin
    test_reset();
    test_nominal();
    for (int i = 0; i < 4; i++) test_lock_glitch();
    for (int i = 0; i < 3; i++) test_loss_of_lock();
    for (int i = 0; i < 3; i++) test_shutdown();
    test_reset_in_run();
`ifdef RCU_PLL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
